// File: rtl/io_clk_meter.sv
// Clock meter: measures high/low time, period and rising-edge count of an
// asynchronous input in AClkH cycles, flags loss of clock, and exposes it on the IO bus.
module io_clk_meter #(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter logic [15:0] CTimeout  = 16'hFFFF
) (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic [15:0] AIoAddr,
    input  logic [63:0] AIoMosi,
    input  logic [3:0]  AIoWrSize,
    input  logic [3:0]  AIoRdSize,
    output logic [63:0] AIoMiso,
    output logic        AIoAddrAck,
    output logic        AIoAddrErr,
    input  logic        AClkM,
    output logic        ALost
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]  sync_q, sync_d;
    logic [15:0] high_cnt_q, high_cnt_d;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [15:0] high_last_q, high_last_d;
    logic [15:0] low_last_q, low_last_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic        got_h_q, got_h_d;
    logic        got_l_q, got_l_d;

    logic        rise_s, fall_s, hit_s, rd_ok_s, clear_s, valid_s;
    logic [16:0] period_sum_s;
    logic [15:0] period_s;
    logic        unused_mosi_s;

    assign rise_s        = sync_q[1] & ~sync_q[2];
    assign fall_s        = ~sync_q[1] & sync_q[2];
    assign hit_s         = (AIoAddr == CAddrBase) && ((AIoWrSize != 4'd0) || (AIoRdSize != 4'd0));
    assign rd_ok_s       = hit_s && (AIoRdSize == 4'h8);
    assign clear_s       = hit_s && (AIoWrSize != 4'd0) && AIoMosi[0];
    assign valid_s       = got_h_q & got_l_q;
    assign period_sum_s  = {1'b0, high_last_q} + {1'b0, low_last_q};
    assign period_s      = period_sum_s[16] ? 16'hFFFF : period_sum_s[15:0];
    assign unused_mosi_s = ^AIoMosi[63:1];

    assign AIoAddrAck = hit_s;
    assign AIoAddrErr = hit_s && (AIoRdSize != 4'd0) && (AIoRdSize != 4'h8);
    assign ALost      = (idle_q == CTimeout);

    // Read mux: data only on a legal 8-byte read hit
    always_comb begin
        AIoMiso = 64'd0;
        if (rd_ok_s) begin
            AIoMiso = {6'd0, ALost, valid_s, edge_cnt_q, period_s, low_last_q, high_last_q};
        end else begin
            AIoMiso = 64'd0;
        end
    end

    // Next-state: everything holds unless the clock enable is high
    always_comb begin
        sync_d      = sync_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        high_last_d = high_last_q;
        low_last_d  = low_last_q;
        idle_d      = idle_q;
        edge_cnt_d  = edge_cnt_q;
        got_h_d     = got_h_q;
        got_l_d     = got_l_q;
        if (AClkHEn) begin
            sync_d = {sync_q[1:0], AClkM};
            // Phase counters restart on an edge even when a clear wins the capture
            if (rise_s) begin
                low_cnt_d  = 16'd0;
                high_cnt_d = 16'd1;
            end else if (fall_s) begin
                high_cnt_d = 16'd0;
                low_cnt_d  = 16'd1;
            end else if (sync_q[1]) begin
                high_cnt_d = sat_inc16(high_cnt_q);
            end else begin
                low_cnt_d = sat_inc16(low_cnt_q);
            end
            if (clear_s) begin
                high_last_d = 16'd0;
                low_last_d  = 16'd0;
                edge_cnt_d  = 8'd0;
                got_h_d     = 1'b0;
                got_l_d     = 1'b0;
            end else if (rise_s) begin
                low_last_d = low_cnt_q;
                got_l_d    = 1'b1;
                edge_cnt_d = edge_cnt_q + 8'd1;
            end else if (fall_s) begin
                high_last_d = high_cnt_q;
                got_h_d     = 1'b1;
            end else begin
                got_h_d = got_h_q;
            end
            if (rise_s || fall_s) begin
                idle_d = 16'd0;
            end else if (idle_q != CTimeout) begin
                idle_d = idle_q + 16'd1;
            end else begin
                idle_d = idle_q;
            end
        end else begin
            sync_d = sync_q;
        end
    end

    // State registers
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            sync_q      <= 3'd0;
            high_cnt_q  <= 16'd0;
            low_cnt_q   <= 16'd0;
            high_last_q <= 16'd0;
            low_last_q  <= 16'd0;
            idle_q      <= 16'd0;
            edge_cnt_q  <= 8'd0;
            got_h_q     <= 1'b0;
            got_l_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            high_last_q <= high_last_d;
            low_last_q  <= low_last_d;
            idle_q      <= idle_d;
            edge_cnt_q  <= edge_cnt_d;
            got_h_q     <= got_h_d;
            got_l_q     <= got_l_d;
        end
    end

endmodule
